// File: rtl/oven_pkg.sv
// rtl/oven_pkg.sv - shared state encoding, BCD time type and BCD arithmetic for the oven cook timer
package oven_pkg;

  localparam int DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] MAX_MIN_TENS = 4'd9;
  localparam logic [DIGIT_W-1:0] MAX_SEC_TENS = 4'd5;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_PAUSE = 3'd2,
    ST_DONE  = 3'd3
  } oven_state_t;

  typedef struct packed {
    logic [DIGIT_W-1:0] min_tens;
    logic [DIGIT_W-1:0] min_units;
    logic [DIGIT_W-1:0] sec_tens;
    logic [DIGIT_W-1:0] sec_units;
  } mmss_t;

  localparam mmss_t MMSS_ZERO = '0;
  localparam mmss_t MMSS_MAX  = {MAX_MIN_TENS, 4'd9, MAX_SEC_TENS, 4'd9};

  // One-second countdown with BCD borrow; callers never apply it to 00:00.
  function automatic mmss_t mmss_dec(input mmss_t t);
    mmss_t r;
    r = t;
    if (t.sec_units != 4'd0) begin
      r.sec_units = t.sec_units - 4'd1;
    end else begin
      r.sec_units = 4'd9;
      if (t.sec_tens != 4'd0) begin
        r.sec_tens = t.sec_tens - 4'd1;
      end else begin
        r.sec_tens = MAX_SEC_TENS;
        if (t.min_units != 4'd0) begin
          r.min_units = t.min_units - 4'd1;
        end else begin
          r.min_units = 4'd9;
          r.min_tens  = t.min_tens - 4'd1;
        end
      end
    end
    return r;
  endfunction

  // Adds minutes/seconds with carry into minutes and saturation at 99:59.
  function automatic mmss_t mmss_add(input mmss_t t, input logic [7:0] add_min,
                                     input logic [7:0] add_sec);
    logic [7:0] s_sum;
    logic [7:0] m_sum;
    mmss_t r;
    s_sum = 8'(t.sec_tens) * 8'd10 + 8'(t.sec_units) + add_sec;
    m_sum = 8'(t.min_tens) * 8'd10 + 8'(t.min_units) + add_min;
    if (s_sum >= 8'd60) begin
      s_sum = s_sum - 8'd60;
      m_sum = m_sum + 8'd1;
    end
    if (m_sum > 8'd99) begin
      r = MMSS_MAX;
    end else begin
      r.min_tens  = 4'(m_sum / 8'd10);
      r.min_units = 4'(m_sum % 8'd10);
      r.sec_tens  = 4'(s_sum / 8'd10);
      r.sec_units = 4'(s_sum % 8'd10);
    end
    return r;
  endfunction

endpackage

// File: rtl/oven_tick_gen.sv
// rtl/oven_tick_gen.sv - CLK_HZ prescaler with enable/hold and clear, emits a 1-cycle tick on terminal count
module oven_tick_gen #(
  parameter int CLK_HZ = 50_000_000
) (
  input  logic clock,
  input  logic reset_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [CW-1:0] TERMINAL = CW'(CLK_HZ - 1);

  logic [CW-1:0] cnt;

  assign tick = en && (cnt == TERMINAL);

  // en low holds the count, which is how a paused cook resumes mid-second.
  always_ff @(posedge clock) begin
    if (!reset_n || clr) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/oven_timer_ctrl.sv
// rtl/oven_timer_ctrl.sv - oven cook-timer FSM with BCD MM:SS time; door interlock under OVEN_DOOR_INTERLOCK_EN
module oven_timer_ctrl
  import oven_pkg::*;
#(
  parameter int CLK_HZ    = 50_000_000,
  parameter int ALARM_SEC = 3,
  parameter int ADD_SEC   = 10
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         btn_add_min,
  input  logic         btn_add_sec,
  input  logic         btn_start,
  input  logic         btn_stop,
  input  logic         door_open,
  output logic [3:0]   min_tens,
  output logic [3:0]   min_units,
  output logic [3:0]   sec_tens,
  output logic [3:0]   sec_units,
  output logic         heater_on,
  output logic         alarm,
  output logic [2:0]   state
);

  localparam int ACW = (ALARM_SEC > 1) ? $clog2(ALARM_SEC + 1) : 1;

  oven_state_t    st_q;
  mmss_t          t_q;
  logic [ACW-1:0] alarm_cnt;

  logic door;
  logic start_ok;
  logic w_stop, w_start, w_min, w_sec, w_add;
  logic force_pause;
  logic tick_en, tick_clr, tick;
  mmss_t t_add, t_dec;

`ifdef OVEN_DOOR_INTERLOCK_EN
  assign door = door_open;
`else
  logic unused_door;
  assign unused_door = door_open;
  assign door = 1'b0;
`endif

  // An open door makes start invisible, so a lower-priority add can still win that cycle.
  assign start_ok    = btn_start && !door;
  assign w_stop      = btn_stop;
  assign w_start     = !btn_stop && start_ok;
  assign w_min       = !btn_stop && !start_ok && btn_add_min;
  assign w_sec       = !btn_stop && !start_ok && !btn_add_min && btn_add_sec;
  assign w_add       = w_min || w_sec;
  assign force_pause = door && (st_q == ST_RUN);

  assign tick_en  = ((st_q == ST_RUN) && !w_stop && !force_pause) || (st_q == ST_DONE);
  assign tick_clr = (st_q == ST_IDLE);

  oven_tick_gen #(.CLK_HZ(CLK_HZ)) u_tick (
    .clock   (clock),
    .reset_n (reset_n),
    .en      (tick_en),
    .clr     (tick_clr),
    .tick    (tick)
  );

  always_comb begin
    t_add = mmss_add(t_q, w_min ? 8'd1 : 8'd0, w_min ? 8'd0 : 8'(ADD_SEC));
    t_dec = mmss_dec(t_q);
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      st_q      <= ST_IDLE;
      t_q       <= MMSS_ZERO;
      heater_on <= 1'b0;
      alarm     <= 1'b0;
      alarm_cnt <= '0;
    end else begin
      case (st_q)
        ST_IDLE: begin
          if (w_stop) begin
            t_q <= MMSS_ZERO;
          end else if (w_start) begin
            if (t_q != MMSS_ZERO) begin
              st_q      <= ST_RUN;
              heater_on <= 1'b1;
            end
          end else if (w_add) begin
            t_q <= t_add;
          end
        end
        ST_RUN: begin
          if (w_stop || force_pause) begin
            st_q      <= ST_PAUSE;
            heater_on <= 1'b0;
          end else if (w_add) begin
            t_q <= t_add;
          end else if (tick) begin
            t_q <= t_dec;
            if (t_dec == MMSS_ZERO) begin
              st_q      <= ST_DONE;
              heater_on <= 1'b0;
              alarm     <= 1'b1;
              alarm_cnt <= '0;
            end
          end
        end
        ST_PAUSE: begin
          if (w_stop) begin
            st_q <= ST_IDLE;
            t_q  <= MMSS_ZERO;
          end else if (w_start) begin
            st_q      <= ST_RUN;
            heater_on <= 1'b1;
          end else if (w_add) begin
            t_q <= t_add;
          end
        end
        ST_DONE: begin
          if (w_stop || w_start) begin
            st_q  <= ST_IDLE;
            alarm <= 1'b0;
          end else if (tick) begin
            if (alarm_cnt == ACW'(ALARM_SEC - 1)) begin
              st_q  <= ST_IDLE;
              alarm <= 1'b0;
            end else begin
              alarm_cnt <= alarm_cnt + 1'b1;
            end
          end
        end
        default: begin
          st_q      <= ST_IDLE;
          t_q       <= MMSS_ZERO;
          heater_on <= 1'b0;
          alarm     <= 1'b0;
        end
      endcase
    end
  end

  assign min_tens  = t_q.min_tens;
  assign min_units = t_q.min_units;
  assign sec_tens  = t_q.sec_tens;
  assign sec_units = t_q.sec_units;
  assign state     = st_q;

endmodule
